dff_en_2seg: RTL and testbench



---
 rtl/dff_en_2seg.sv | 33 +++
 tb/tb_dff_en_2seg.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/dff_en_2seg.sv
// D flip-flop with a synchronous load enable and an asynchronous active-high reset.
// Two segments: the state register q_reg and the next-state mux q_next.
module dff_en_2seg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_reg <= '0;
    end else begin
      q_reg <= q_next;
    end
  end

  always_comb begin
    q_next = q_reg;
    if (en) begin
      q_next = d;
    end
  end

  assign q = q_reg;

endmodule

// File: tb/tb_dff_en_2seg.sv
// Self-checking bench for dff_en_2seg: 1-bit and 8-bit instances driven from
// a vector table, with a scoreboard queue and hand-written reset sequences.
module tb_dff_en_2seg;

  logic       clk = 1'b0;
  logic       reset;
  logic       en1, en8;
  logic [0:0] d1, q1;
  logic [7:0] d8, q8;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      name;
    logic       wide;
    logic       en;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    string      name;
    logic       wide;
    logic [7:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];

  dff_en_2seg #(.WIDTH(1)) u_dff1 (
    .clk  (clk),
    .reset(reset),
    .en   (en1),
    .d    (d1),
    .q    (q1)
  );

  dff_en_2seg #(.WIDTH(8)) u_dff8 (
    .clk  (clk),
    .reset(reset),
    .en   (en8),
    .d    (d8),
    .q    (q8)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(input string name, input logic wide, input logic en,
                              input logic [7:0] d, input logic [7:0] exp);
    vec_t v;
    v.name = name; v.wide = wide; v.en = en; v.d = d; v.exp = exp;
    vecs.push_back(v);
  endfunction

  function automatic logic [7:0] qsel(input logic wide);
    return wide ? q8 : {7'd0, q1};
  endfunction

  // One vector per cycle: drive at the falling edge, glitch d in the low half
  // (settled well before the rising edge), then compare just after the edge.
  task automatic apply(input vec_t v);
    sb_t e;
    @(negedge clk);
    if (v.wide) begin
      en8 = v.en; d8 = ~v.d; en1 = 1'b0;
    end else begin
      en1 = v.en; d1 = ~v.d[0]; en8 = 1'b0;
    end
    #1;
    if (v.wide) d8 = v.d; else d1 = v.d[0];
    e.name = v.name; e.wide = v.wide; e.exp = v.exp;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk(e.name, qsel(e.wide), e.exp);
    if (e.wide) d8 = ~d8; else d1 = ~d1;
    #2;
    chk({e.name, "_post_glitch"}, qsel(e.wide), e.exp);
  endtask

  initial begin
    reset = 1'b0; en1 = 1'b0; en8 = 1'b0; d1 = '0; d8 = '0;

    // Power-up: q is unspecified, so only toggle d before the first reset.
    repeat (6) begin
      @(clk);
      d1 = 1'($urandom_range(1));
      d8 = 8'($urandom_range(255));
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_q1", qsel(1'b0), 8'h00);
    chk("async_reset_q8", qsel(1'b1), 8'h00);
    #3 reset = 1'b0;

    add("hold_after_reset", 1'b0, 1'b0, 8'h01, 8'h00);
    add("hold_after_reset", 1'b0, 1'b0, 8'h00, 8'h00);
    add("hold_after_reset", 1'b0, 1'b0, 8'h01, 8'h00);
    add("follow_d", 1'b0, 1'b1, 8'h01, 8'h01);
    add("follow_d", 1'b0, 1'b1, 8'h00, 8'h00);
    add("follow_d", 1'b0, 1'b1, 8'h01, 8'h01);
    add("follow_d", 1'b0, 1'b1, 8'h01, 8'h01);
    add("follow_d", 1'b0, 1'b1, 8'h00, 8'h00);
    add("follow_d", 1'b0, 1'b1, 8'h00, 8'h00);
    add("load_one", 1'b0, 1'b1, 8'h01, 8'h01);
    for (int unsigned i = 0; i < 6; i++)
      add("hold_en0", 1'b0, 1'b0, 8'(i[0]), 8'h01);
    add("wide_load_a5", 1'b1, 1'b1, 8'hA5, 8'hA5);
    add("wide_load_3c", 1'b1, 1'b1, 8'h3C, 8'h3C);
    add("wide_hold_ff", 1'b1, 1'b0, 8'hFF, 8'h3C);
    add("wide_hold_ff", 1'b1, 1'b0, 8'hFF, 8'h3C);

    foreach (vecs[i]) apply(vecs[i]);

    // Reset between edges with en=1, d=1, then reset coincident with an edge.
    @(negedge clk); en1 = 1'b1; d1 = 1'b1; en8 = 1'b0;
    @(posedge clk); #1 chk("preload_one", qsel(1'b0), 8'h01);
    #2 reset = 1'b1;
    #1 chk("reset_mid_cycle", qsel(1'b0), 8'h00);
    @(posedge clk); #1 chk("reset_held_over_edge", qsel(1'b0), 8'h00);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1 chk("reload_after_release", qsel(1'b0), 8'h01);
    @(posedge clk);
    reset = 1'b1;
    #1 chk("reset_at_edge", qsel(1'b0), 8'h00);
    chk("reset_at_edge_q8", qsel(1'b1), 8'h00);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1 chk("release_then_load", qsel(1'b0), 8'h01);
    chk("wide_stays_zero_en0", qsel(1'b1), 8'h00);

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: actual=%0d required=0 entries", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
